// File: rtl/pipeline_feed_queue_if.sv
// rtl/pipeline_feed_queue_if.sv - upstream/pipeline handshake bundle for pipeline_feed_queue
// master drives the upstream word and pipeline controls; slave is the queue itself.
interface pipeline_feed_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic [CW-1:0]    count;
  logic             holding;

  modport master (
    output in_data, in_valid, stall, flush,
    input  in_ready, data, data_valid, count, holding
  );

  modport slave (
    input  in_data, in_valid, stall, flush,
    output in_ready, data, data_valid, count, holding
  );
endinterface

// File: rtl/pipeline_feed_queue.sv
// rtl/pipeline_feed_queue.sv - word queue feeding the IF stage with stall, flush and refill bubbles
// A flush empties the queue and forces FLUSH_CYCLES bubble cycles (HOLD) before popping resumes.
module pipeline_feed_queue #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 4,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] BUBBLE       = '0
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_feed_queue_if.slave q_if
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic in_ready;
  logic push;
  logic pop;

  // No full-pop bypass: a full queue refuses a push even on a popping cycle.
  always_comb begin
    in_ready = !q_if.flush && (count_q < CW'(DEPTH));
    push     = q_if.in_valid && in_ready;
    pop      = (state_q == ST_RUN) && !q_if.flush && !q_if.stall && (count_q != '0);
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;

    if (q_if.flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      data_d       = BUBBLE;
      data_valid_d = 1'b0;
      if (FLUSH_CYCLES > 0) begin
        state_d    = ST_HOLD;
        hold_cnt_d = HW'(FLUSH_CYCLES);
      end else begin
        state_d    = ST_RUN;
        hold_cnt_d = '0;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      unique case (state_q)
        ST_RUN: begin
          if (!q_if.stall) begin
            if (pop) begin
              data_d       = mem_q[rd_ptr_q];
              data_valid_d = 1'b1;
            end else begin
              data_d       = BUBBLE;
              data_valid_d = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          // Refill penalty counts edges regardless of stall.
          data_d       = BUBBLE;
          data_valid_d = 1'b0;
          if (hold_cnt_q <= HW'(1)) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      hold_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      data_q       <= BUBBLE;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= q_if.in_data;
    end
  end

  assign q_if.in_ready   = in_ready;
  assign q_if.data       = data_q;
  assign q_if.data_valid = data_valid_q;
  assign q_if.count      = count_q;
  assign q_if.holding    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipeline_feed_queue.sv
// tb/tb_pipeline_feed_queue.sv - directed self-checking bench for pipeline_feed_queue
// Each task drives one scenario and compares against hand-computed values.
module tb_pipeline_feed_queue;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipeline_feed_queue_if #(.WIDTH(32), .DEPTH(4)) q_if ();

  pipeline_feed_queue #(
    .WIDTH(32), .DEPTH(4), .FLUSH_CYCLES(2), .BUBBLE(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q_if(q_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q_if.in_valid = 1'b0;
    q_if.in_data  = 32'h0;
    q_if.stall    = 1'b0;
    q_if.flush    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (q_if.data !== 32'h0) $display("FAIL rst_data got %0h want 0", q_if.data); else passed++;
    checks++; if (q_if.data_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", q_if.data_valid); else passed++;
    checks++; if (q_if.count !== 3'd0) $display("FAIL rst_count got %0d want 0", q_if.count); else passed++;
    checks++; if (q_if.holding !== 1'b0) $display("FAIL rst_holding got %0b want 0", q_if.holding); else passed++;
    checks++; if (q_if.in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", q_if.in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'd1;
    tick();
    checks++; if (q_if.data_valid !== 1'b0) $display("FAIL b2b_latency got valid %0b want 0", q_if.data_valid); else passed++;
    checks++; if (q_if.count !== 3'd1) $display("FAIL b2b_count1 got %0d want 1", q_if.count); else passed++;
    q_if.in_data = 32'd2;
    tick();
    checks++; if (q_if.data !== 32'd1 || q_if.data_valid !== 1'b1) $display("FAIL b2b_word1 got %0h/%0b want 1/1", q_if.data, q_if.data_valid); else passed++;
    checks++; if (q_if.count !== 3'd1) $display("FAIL b2b_pushpop_count got %0d want 1", q_if.count); else passed++;
    q_if.in_data = 32'd3;
    tick();
    checks++; if (q_if.data !== 32'd2) $display("FAIL b2b_word2 got %0h want 2", q_if.data); else passed++;
    q_if.in_valid = 1'b0;
    tick();
    checks++; if (q_if.data !== 32'd3 || q_if.count !== 3'd0) $display("FAIL b2b_word3 got %0h cnt %0d want 3 cnt 0", q_if.data, q_if.count); else passed++;
    tick();
    checks++; if (q_if.data !== 32'h0 || q_if.data_valid !== 1'b0) $display("FAIL b2b_drain got %0h/%0b want 0/0", q_if.data, q_if.data_valid); else passed++;
  endtask

  task automatic test_fill_stall();
    int exp_words[3] = '{3, 4, 5};
    q_if.stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = i;
      tick();
    end
    checks++; if (q_if.count !== 3'd4) $display("FAIL fill_count got %0d want 4", q_if.count); else passed++;
    q_if.in_data = 32'd5;
    #1;
    checks++; if (q_if.in_ready !== 1'b0) $display("FAIL fill_full_ready got %0b want 0", q_if.in_ready); else passed++;
    tick();
    checks++; if (q_if.count !== 3'd4 || q_if.data_valid !== 1'b0) $display("FAIL fill_stall_hold got cnt %0d v %0b want 4/0", q_if.count, q_if.data_valid); else passed++;
    q_if.stall = 1'b0;
    #1;
    checks++; if (q_if.in_ready !== 1'b0) $display("FAIL fill_no_bypass got %0b want 0", q_if.in_ready); else passed++;
    tick();
    checks++; if (q_if.data !== 32'd1 || q_if.count !== 3'd3) $display("FAIL fill_word1 got %0h cnt %0d want 1 cnt 3", q_if.data, q_if.count); else passed++;
    checks++; if (q_if.in_ready !== 1'b1) $display("FAIL fill_ready_again got %0b want 1", q_if.in_ready); else passed++;
    tick();
    checks++; if (q_if.data !== 32'd2 || q_if.count !== 3'd3) $display("FAIL fill_word2 got %0h cnt %0d want 2 cnt 3", q_if.data, q_if.count); else passed++;
    q_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q_if.data !== exp_words[i] || q_if.data_valid !== 1'b1) $display("FAIL fill_order[%0d] got %0h want %0h", i, q_if.data, exp_words[i]); else passed++;
    end
    tick();
    checks++; if (q_if.data_valid !== 1'b0 || q_if.count !== 3'd0) $display("FAIL fill_empty got v %0b cnt %0d want 0/0", q_if.data_valid, q_if.count); else passed++;
  endtask

  task automatic test_stall_flush();
    q_if.stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = i;
      tick();
    end
    q_if.in_valid = 1'b0;
    q_if.stall    = 1'b0;
    tick();
    tick();
    checks++; if (q_if.data !== 32'd2 || q_if.count !== 3'd2) $display("FAIL sf_setup got %0h cnt %0d want 2 cnt 2", q_if.data, q_if.count); else passed++;
    q_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q_if.data !== 32'd2 || q_if.data_valid !== 1'b1 || q_if.count !== 3'd2) $display("FAIL stall_hold[%0d] got %0h/%0b cnt %0d want 2/1 cnt 2", i, q_if.data, q_if.data_valid, q_if.count); else passed++;
    end
    q_if.stall    = 1'b0;
    q_if.flush    = 1'b1;
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'd7;
    #1;
    checks++; if (q_if.in_ready !== 1'b0) $display("FAIL flush_ready got %0b want 0", q_if.in_ready); else passed++;
    tick();
    checks++; if (q_if.data !== 32'h0 || q_if.data_valid !== 1'b0 || q_if.count !== 3'd0) $display("FAIL flush_clear got %0h/%0b cnt %0d want 0/0 cnt 0", q_if.data, q_if.data_valid, q_if.count); else passed++;
    checks++; if (q_if.holding !== 1'b1) $display("FAIL flush_hold1 got %0b want 1", q_if.holding); else passed++;
    q_if.flush   = 1'b0;
    q_if.in_data = 32'd9;
    tick();
    checks++; if (q_if.holding !== 1'b1 || q_if.count !== 3'd1 || q_if.data_valid !== 1'b0) $display("FAIL hold_push got h %0b cnt %0d v %0b want 1/1/0", q_if.holding, q_if.count, q_if.data_valid); else passed++;
    q_if.in_valid = 1'b0;
    tick();
    checks++; if (q_if.holding !== 1'b0 || q_if.data_valid !== 1'b0) $display("FAIL hold_exit got h %0b v %0b want 0/0", q_if.holding, q_if.data_valid); else passed++;
    tick();
    checks++; if (q_if.data !== 32'd9 || q_if.data_valid !== 1'b1 || q_if.count !== 3'd0) $display("FAIL refill_word got %0h/%0b cnt %0d want 9/1 cnt 0", q_if.data, q_if.data_valid, q_if.count); else passed++;
    tick();
  endtask

  task automatic test_flush_in_hold();
    logic exp_h[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic fl[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      q_if.flush = fl[i];
      tick();
      checks++; if (q_if.holding !== exp_h[i]) $display("FAIL reflush_hold[%0d] got %0b want %0b", i, q_if.holding, exp_h[i]); else passed++;
    end
  endtask

  task automatic test_rst_in_hold();
    q_if.flush = 1'b1;
    tick();
    q_if.flush    = 1'b0;
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'hA;
    tick();
    q_if.in_valid = 1'b0;
    checks++; if (q_if.holding !== 1'b1 || q_if.count !== 3'd1) $display("FAIL rsth_setup got h %0b cnt %0d want 1/1", q_if.holding, q_if.count); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (q_if.holding !== 1'b0 || q_if.count !== 3'd0 || q_if.data_valid !== 1'b0 || q_if.data !== 32'h0) $display("FAIL rsth_values got h %0b cnt %0d %0h/%0b want 0/0 0/0", q_if.holding, q_if.count, q_if.data, q_if.data_valid); else passed++;
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'h11;
    tick();
    q_if.in_valid = 1'b0;
    tick();
    checks++; if (q_if.data !== 32'h11 || q_if.data_valid !== 1'b1) $display("FAIL rsth_resume got %0h/%0b want 11/1", q_if.data, q_if.data_valid); else passed++;
    tick();
  endtask

  task automatic test_rst_mid_stall();
    q_if.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 32'h20 + i;
      tick();
    end
    q_if.in_valid = 1'b0;
    q_if.stall    = 1'b0;
    tick();
    checks++; if (q_if.data !== 32'h21 || q_if.count !== 3'd2) $display("FAIL rsts_setup got %0h cnt %0d want 21 cnt 2", q_if.data, q_if.count); else passed++;
    q_if.stall = 1'b1;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (q_if.data !== 32'h0 || q_if.data_valid !== 1'b0 || q_if.count !== 3'd0) $display("FAIL rsts_values got %0h/%0b cnt %0d want 0/0 cnt 0", q_if.data, q_if.data_valid, q_if.count); else passed++;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_back_to_back();
    test_fill_stall();
    test_stall_flush();
    test_flush_in_hold();
    test_rst_in_hold();
    test_rst_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
